uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver for 8N1 frames, the receive-side counterpart of the team's UART transmitter. It sits between the external RX pin and the design's byte-level logic. It synchronises the asynchronous line, qualifies the start bit at mid-bit, and samples eight data bits LSB-first plus one stop bit. Each good byte is presented on a valid/ready handshake, with framing and overrun errors flagged.

## Interface
- BAUD_COUNT_WIDTH, 9, width of the baud counter.
- FULL_BAUD_COUNT_TOP, 434, clk cycles per bit.
- HALF_BAUD_COUNT_TOP, 217, clk cycles to the mid-point of the start bit.
- clk  in  1  system clock; one clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- serial_dat_in  in  1  asynchronous RX line; idle high.
- rx_ready  in  1  consumer accepts `rx_data` when high with `rx_valid`.
- rx_data  out  8  received byte; stable while `rx_valid` is high.
- rx_valid  out  1  byte available; held until accepted.
- rx_busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- overrun_err  out  1  one-cycle pulse when a good byte completes while `rx_valid` is still high.

## Operation
- Input path: two-flop synchroniser, both flops reset to 1. A third flop holds the previous synchronised value for falling-edge detection.
- Baud counter: BAUD_COUNT_WIDTH bits. Clears on every state change and on every bit sample. Otherwise increments by 1; never wraps mid-bit.
- Bit counter: 3 bits, counts data bits 0..7.
- Shift register: 8 bits. Each data sample shifts in at bit 7 and shifts right, so the LSB arrives first.
- States:
  - IDLE: on a synchronised 1->0 edge -> START. A line held low does not retrigger.
  - START: at count == HALF_BAUD_COUNT_TOP-1, sample the line. Low -> DATA. High -> IDLE (glitch rejected, no error).
  - DATA: at count == FULL_BAUD_COUNT_TOP-1, sample into the shift register. After the 8th sample -> STOP.
  - STOP: at count == FULL_BAUD_COUNT_TOP-1, sample the stop bit, then -> IDLE in the same cycle.
- Stop bit sampled high, with `rx_valid` low or `rx_ready` high in that cycle: load `rx_data`, set `rx_valid`.
- Stop bit sampled high, with `rx_valid` high and `rx_ready` low: pulse `overrun_err`. The new byte is dropped; the old byte and `rx_valid` are kept.
- Stop bit sampled low: pulse `frame_err`. The byte is dropped; `rx_valid` and `rx_data` are unchanged.
- Handshake: `rx_valid` clears the cycle after `rx_valid && rx_ready`, unless a new byte loads in that same cycle, in which case it stays high with the new data.
- Reset (asserted at any time, including mid-frame): FSM returns to IDLE; all counters clear; shift register resets to 0. Outputs reset as follows:
  - `rx_data` = 0
  - `rx_valid` = 0
  - `rx_busy` = 0
  - `frame_err` = 0
  - `overrun_err` = 0

## Timing
- All outputs are registered.
- Latency from the first clk edge that sees the line low at the synchroniser input to `rx_valid` high is 3 + HALF_BAUD_COUNT_TOP + 9*FULL_BAUD_COUNT_TOP cycles (synchroniser plus edge detect, then START, DATA ×8 and STOP).
- `rx_busy` rises in the cycle after the edge is detected. It falls in the same cycle that `rx_valid`, `frame_err` or `overrun_err` updates.
- IDLE is re-entered half a bit into the stop bit, so back-to-back frames with no idle gap are received without loss.
- `frame_err` and `overrun_err` are exactly one cycle wide and are never asserted together.

## Configuration
- Macro UART_RX_MAJORITY_EN.
- Defined: each sample (start, data and stop) is the 2-of-3 majority of the synchronised line taken at count-2, count-1 and count, where count is the sampling point above. The decision is still made at the sampling count, so latency is unchanged.
- Undefined: a single sample is taken at the sampling count. The majority logic and its sample register are not synthesised.

## Test plan
- Bench overrides: FULL_BAUD_COUNT_TOP=16, HALF_BAUD_COUNT_TOP=8.
- Send 0xA5, `rx_ready`=1 -> `rx_valid` pulses one cycle with `rx_data`=0xA5, 3+8+144=155 cycles after the start edge; no error pulse.
- Send 0x3C then 0xC3 back-to-back with no gap, `rx_ready`=0 -> the first byte is held at 0x3C and `overrun_err` pulses once at the second stop. Then raise `rx_ready` -> `rx_valid` clears the next cycle.
- Send 0x55 with the stop bit forced low -> `frame_err` pulses once and `rx_valid` stays 0. Then hold the line low for 40 bit times -> no further `frame_err`.
- Pulse the line low for 4 cycles in IDLE -> START is entered and then rejected; `rx_busy` high for about 9 cycles; no `rx_valid`, no error.
- Assert `rst` mid-DATA, then send 0x81 -> all outputs are 0 during reset, and 0x81 is then received correctly.
- With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted glitch at each data sampling point of 0xF0 -> `rx_data`=0xF0. Without the macro, the same glitches corrupt the byte.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready byte output and framing/overrun flags.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority vote at every sample point).
module uart_rx #(
    parameter int unsigned BAUD_COUNT_WIDTH    = 9,
    parameter int unsigned FULL_BAUD_COUNT_TOP = 434,
    parameter int unsigned HALF_BAUD_COUNT_TOP = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_dat_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam logic [BAUD_COUNT_WIDTH-1:0] FullLast =
        BAUD_COUNT_WIDTH'(FULL_BAUD_COUNT_TOP - 1);
    localparam logic [BAUD_COUNT_WIDTH-1:0] HalfLast =
        BAUD_COUNT_WIDTH'(HALF_BAUD_COUNT_TOP - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  sync_q;
    logic                        prev_q;
    logic [BAUD_COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]                  bit_q, bit_d;
    logic [7:0]                  shift_q, shift_d;
    logic [7:0]                  data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        ferr_q, ferr_d;
    logic                        oerr_q, oerr_d;
    logic                        line_s;
    logic                        falling;

    // Two-flop synchroniser plus previous-value flop for edge detection; idle level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], serial_dat_in};
            prev_q <= sync_q[1];
        end
    end

    assign falling = prev_q & ~sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Last two synchronised values, so the vote covers count-2, count-1 and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign line_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q[1]) |
                    (hist_q[0] & sync_q[1]);
`else
    assign line_s = sync_q[1];
`endif

    // FSM, counters, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    // Next-state logic: counter clears at every sample point, which is also every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (falling) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A line back high at mid-start is a glitch: drop it silently.
                    state_d = line_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    shift_d = {line_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    // Leaving mid-stop-bit lets a following start edge be caught with no gap.
                    state_d = StIdle;
                    if (!line_s) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        oerr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = busy_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized checks of uart_rx against a frame-level reference model.
module tb_uart_rx;

    localparam int F   = 16;
    localparam int H   = 8;
    localparam int LAT = 3 + H + 9 * F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun_err;

    int checks = 0;
    int errors = 0;

    uart_rx #(
        .BAUD_COUNT_WIDTH   (9),
        .FULL_BAUD_COUNT_TOP(F),
        .HALF_BAUD_COUNT_TOP(H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_dat_in(serial),
        .rx_ready     (ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    // Monitor: event statistics sampled 1 time unit after each rising edge.
    int         cyc = 0;
    int         rises = 0, rise_cyc = 0, ferr_cnt = 0, oerr_cnt = 0, busy_cnt = 0;
    int         wide_cnt = 0, both_cnt = 0, vlen = 0, last_vlen = 0;
    logic [7:0] rise_data = 8'h00;
    logic       vprev = 1'b0, fprev = 1'b0, oprev = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_valid && !vprev) begin
            rises++;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        if (rx_valid) vlen++;
        else if (vprev) begin
            last_vlen = vlen;
            vlen      = 0;
        end
        if (frame_err) ferr_cnt++;
        if (overrun_err) oerr_cnt++;
        if ((frame_err && fprev) || (overrun_err && oprev)) wide_cnt++;
        if (frame_err && overrun_err) both_cnt++;
        if (rx_busy) busy_cnt++;
        vprev = rx_valid;
        fprev = frame_err;
        oprev = overrun_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the line at v for n rising edges (changes happen on falling edges).
    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            serial = v;
            @(negedge clk);
        end
    endtask

    // One 8N1 frame; optionally invert the line for one cycle at each data mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch);
        drive(1'b0, F);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                drive(b[i], H);
                drive(~b[i], 1);
                drive(b[i], F - H - 1);
            end else begin
                drive(b[i], F);
            end
        end
        drive(stop, F);
    endtask

    int         c0, base_r, base_f, base_o, base_b;
    logic [7:0] b;
    logic [7:0] exp_glitch;

    initial begin
        @(negedge clk);
        drive(1'b1, 3);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_oerr", 32'(overrun_err), 32'h0);
        rst = 1'b0;
        drive(1'b1, 5);

        // Single byte with consumer ready: one-cycle valid at the modelled latency.
        ready  = 1'b1;
        base_r = rises; base_f = ferr_cnt; base_o = oerr_cnt;
        c0     = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, F);
        check("a5_rises", 32'(rises - base_r), 32'd1);
        check("a5_latency", 32'(rise_cyc - c0), 32'(LAT));
        check("a5_data", 32'(rise_data), 32'hA5);
        check("a5_vlen", 32'(last_vlen), 32'd1);
        check("a5_ferr", 32'(ferr_cnt - base_f), 32'd0);
        check("a5_oerr", 32'(oerr_cnt - base_o), 32'd0);

        // Random bytes with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            drive(1'b1, $urandom_range(0, 20));
            base_r = rises;
            c0     = cyc;
            send_frame(b, 1'b1, 1'b0);
            drive(1'b1, 2);
            check("rnd_rises", 32'(rises - base_r), 32'd1);
            check("rnd_data", 32'(rise_data), 32'(b));
            check("rnd_latency", 32'(rise_cyc - c0), 32'(LAT));
        end
        drive(1'b1, F);

        // Back-to-back frames with consumer stalled: second byte overruns.
        ready  = 1'b0;
        base_r = rises; base_f = ferr_cnt; base_o = oerr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        drive(1'b1, F);
        check("ovr_rises", 32'(rises - base_r), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h3C);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_oerr", 32'(oerr_cnt - base_o), 32'd1);
        check("ovr_ferr", 32'(ferr_cnt - base_f), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("ovr_accept", 32'(rx_valid), 32'h0);

        // Framing error, then a long low line must not retrigger.
        drive(1'b1, F);
        base_r = rises; base_f = ferr_cnt; base_o = oerr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        drive(1'b0, 2);
        check("fe_ferr", 32'(ferr_cnt - base_f), 32'd1);
        check("fe_valid", 32'(rx_valid), 32'h0);
        drive(1'b0, 40 * F);
        check("fe_hold_ferr", 32'(ferr_cnt - base_f), 32'd1);
        check("fe_hold_busy", 32'(rx_busy), 32'h0);
        drive(1'b1, 2 * F);
        check("fe_rises", 32'(rises - base_r), 32'd0);
        check("fe_oerr", 32'(oerr_cnt - base_o), 32'd0);

        // Short low glitch: start rejected at mid-bit, busy for about half a bit.
        base_r = rises; base_f = ferr_cnt; base_o = oerr_cnt; base_b = busy_cnt;
        drive(1'b0, 4);
        drive(1'b1, 3 * F);
        check("gl_busy_len", 32'((busy_cnt - base_b) >= H - 1 && (busy_cnt - base_b) <= H + 2),
              32'd1);
        check("gl_rises", 32'(rises - base_r), 32'd0);
        check("gl_err", 32'((ferr_cnt - base_f) + (oerr_cnt - base_o)), 32'd0);

        // Reset in the middle of the data bits, then a clean frame.
        drive(1'b0, F);
        drive(1'b1, F);
        drive(1'b0, F);
        check("mid_busy", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mr_data", 32'(rx_data), 32'h0);
        check("mr_valid", 32'(rx_valid), 32'h0);
        check("mr_busy", 32'(rx_busy), 32'h0);
        check("mr_err", 32'({frame_err, overrun_err}), 32'h0);
        drive(1'b1, 3);
        rst = 1'b0;
        drive(1'b1, F);
        base_r = rises;
        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1, F);
        check("post_rst_rises", 32'(rises - base_r), 32'd1);
        check("post_rst_data", 32'(rise_data), 32'h81);

        // One-cycle inverted glitch at each data sample point.
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = 8'hF0;
`else
        exp_glitch = 8'h0F;
`endif
        base_r = rises;
        send_frame(8'hF0, 1'b1, 1'b1);
        drive(1'b1, F);
        check("glitch_rises", 32'(rises - base_r), 32'd1);
        check("glitch_data", 32'(rise_data), 32'(exp_glitch));

        // Error pulses are single-cycle and mutually exclusive across the whole run.
        check("err_width", 32'(wide_cnt), 32'd0);
        check("err_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
